// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: requester indices
// and the width of the contention counter.
package regfile_write_arbiter_pkg;

  localparam int REQ_WB     = 0;
  localparam int REQ_LM     = 1;
  localparam int CONFLICT_W = 16;

  function automatic logic [CONFLICT_W-1:0] sat_inc(input logic [CONFLICT_W-1:0] v);
    return (v == '1) ? v : v + CONFLICT_W'(1);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-way round-robin grant with a one-bit priority pointer.
//   state  | meaning
//   PRI_WB | on contention, WB requester (0) wins
//   PRI_LM | on contention, load-multiple requester (1) wins
module rr_arb2
  import regfile_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  localparam logic [0:0] PRI_WB = 1'b0;
  localparam logic [0:0] PRI_LM = 1'b1;

  logic [0:0] pri_q;

  // Ready is masked during reset so no transfer is seen by a requester.
  always_comb begin
    grant = 2'b00;
    if (!reset && !hold) begin
      if (valid[REQ_WB] && valid[REQ_LM]) begin
        grant[REQ_WB] = (pri_q == PRI_WB);
        grant[REQ_LM] = (pri_q == PRI_LM);
      end else begin
        grant = valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pri_q <= PRI_WB;
    end else if (grant[REQ_WB]) begin
      pri_q <= PRI_LM;
    end else if (grant[REQ_LM]) begin
      pri_q <= PRI_WB;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two write requesters onto a shared register-file D bus with
// one registered stage of one-hot load enable and data.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int R0_ZERO  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  req0_valid,
  input  logic [ADDR_W-1:0]     req0_addr,
  input  logic [DATA_W-1:0]     req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_W-1:0]     req1_addr,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  req1_ready,
  output logic [NUM_REGS-1:0]   le_out,
  output logic [DATA_W-1:0]     d_out,
  output logic                  err_pulse,
  output logic                  last_grant,
  output logic [CONFLICT_W-1:0] conflict_cnt
);

  logic [1:0]          grant;
  logic                xfer;
  logic                sel_lm;
  logic                contested;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] le_next;
  logic                err_next;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .hold  (hold),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[REQ_WB];
  assign req1_ready = grant[REQ_LM];
  assign xfer       = |grant;
  assign sel_lm     = grant[REQ_LM];
  assign sel_addr   = sel_lm ? req1_addr : req0_addr;
  assign sel_data   = sel_lm ? req1_data : req0_data;
  assign contested  = req0_valid & req1_valid & ~hold;

  // Out-of-range addresses raise the error flag; register 0 is silently dropped.
  always_comb begin
    le_next  = '0;
    err_next = 1'b0;
    if (xfer) begin
      if (int'(sel_addr) >= NUM_REGS) begin
        err_next = 1'b1;
      end else if (!(R0_ZERO != 0 && sel_addr == '0)) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          le_next[i] = (int'(sel_addr) == i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      le_out       <= '0;
      d_out        <= '0;
      err_pulse    <= 1'b0;
      last_grant   <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      le_out    <= le_next;
      err_pulse <= err_next;
      if (xfer) begin
        d_out      <= sel_data;
        last_grant <= sel_lm;
      end
      if (contested) begin
        conflict_cnt <= sat_inc(conflict_cnt);
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic
// against a behavioural model, on a 16-register and a 12-register instance.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset, hold;
  logic        v0, v1;
  logic [3:0]  a0, a1;
  logic [31:0] d0, d1;

  logic        r0a, r1a, erra, lga;
  logic [15:0] lea, cnta;
  logic [31:0] da;
  logic        r0b, r1b, errb, lgb;
  logic [11:0] leb;
  logic [15:0] cntb;
  logic [31:0] db;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut_a (
    .clk(clk), .reset(reset), .hold(hold),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0a),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1a),
    .le_out(lea), .d_out(da), .err_pulse(erra), .last_grant(lga), .conflict_cnt(cnta)
  );

  regfile_write_arbiter #(.NUM_REGS(12)) dut_b (
    .clk(clk), .reset(reset), .hold(hold),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0b),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1b),
    .le_out(leb), .d_out(db), .err_pulse(errb), .last_grant(lgb), .conflict_cnt(cntb)
  );

  // Behavioural model state
  int          m_pref, m_lg, m_cnt, last_g;
  logic [15:0] m_le_a;
  logic [11:0] m_le_b;
  logic [31:0] m_d;
  logic        m_err_a, m_err_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check readies, advance model at the edge, check registered outputs.
  task automatic cycle();
    int g;
    logic [3:0]  ad;
    if (reset || hold)   g = -1;
    else if (v0 && v1)   g = m_pref;
    else if (v0)         g = 0;
    else if (v1)         g = 1;
    else                 g = -1;
    #1;
    chk("ready0_a", r0a, g == 0);
    chk("ready1_a", r1a, g == 1);
    chk("ready0_b", r0b, g == 0);
    chk("ready1_b", r1b, g == 1);
    @(posedge clk);
    if (reset) begin
      m_pref = 0; m_lg = 0; m_cnt = 0; m_le_a = '0; m_le_b = '0;
      m_d = '0; m_err_a = 0; m_err_b = 0;
    end else begin
      if (v0 && v1 && !hold && m_cnt < 65535) m_cnt++;
      m_le_a = '0; m_le_b = '0; m_err_a = 0; m_err_b = 0;
      if (g >= 0) begin
        ad     = (g == 1) ? a1 : a0;
        m_d    = (g == 1) ? d1 : d0;
        m_lg   = g;
        m_pref = 1 - g;
        if (ad != 0) m_le_a = 16'(1) << ad;
        if (ad >= 12) m_err_b = 1;
        else if (ad != 0) m_le_b = 12'(1) << ad;
      end
    end
    last_g = g;
    @(negedge clk);
    chk("le_a", lea, m_le_a);
    chk("le_b", leb, m_le_b);
    chk("d_a", da, m_d);
    chk("d_b", db, m_d);
    chk("err_a", erra, m_err_a);
    chk("err_b", errb, m_err_b);
    chk("lg_a", lga, m_lg[0]);
    chk("lg_b", lgb, m_lg[0]);
    chk("cnt_a", cnta, m_cnt[15:0]);
    chk("cnt_b", cntb, m_cnt[15:0]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0;
    v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    m_pref = 0; m_lg = 0; m_cnt = 0; m_le_a = '0; m_le_b = '0;
    m_d = '0; m_err_a = 0; m_err_b = 0; last_g = -1;
    @(negedge clk);
    v0 = 1; v1 = 1;
    cycle();
    chk("rst_le", lea, 32'h0);
    chk("rst_d", da, 32'h0);
    chk("rst_cnt", cnta, 32'h0);
    v0 = 0; v1 = 0;
    reset = 1'b0;

    // Single write
    v0 = 1; a0 = 4'd5; d0 = 32'hDEADBEEF;
    #1 chk("single_ready", r0a, 1'b1);
    cycle();
    chk("single_le", lea, 32'h0020);
    chk("single_d", da, 32'hDEADBEEF);
    v0 = 0;
    cycle();
    chk("idle_le", lea, 32'h0);
    chk("idle_d_hold", da, 32'hDEADBEEF);

    // Contention from reset
    do_reset();
    v0 = 1; a0 = 4'd3; d0 = 32'h11111111;
    v1 = 1; a1 = 4'd4; d1 = 32'h22222222;
    cycle();
    chk("cont_lg1", lga, 1'b0);
    d0 = 32'h33333333;
    cycle();
    chk("cont_lg2", lga, 1'b1);
    chk("cont_le2", lea, 32'h0010);
    chk("cont_cnt", cnta, 32'd2);
    v0 = 0; v1 = 0;
    cycle();

    // Hold: move the pointer to req1 first
    v0 = 1; a0 = 4'd2;
    cycle();
    v1 = 1; hold = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_le", lea, 32'h0);
      chk("hold_cnt", cnta, 32'd2);
    end
    hold = 0;
    cycle();
    chk("hold_rel_lg", lga, 1'b1);
    chk("hold_rel_cnt", cnta, 32'd3);
    v0 = 0; v1 = 0;
    cycle();

    // Boundary addresses
    v0 = 1; a0 = 4'd0; d0 = 32'hA5A5A5A5;
    cycle();
    chk("a0_le", lea, 32'h0);
    chk("a0_err", erra, 1'b0);
    chk("a0_d", da, 32'hA5A5A5A5);
    a0 = 4'd15;
    cycle();
    chk("a15_le", lea, 32'h8000);
    chk("a15_err_b", errb, 1'b1);
    a0 = 4'd13;
    cycle();
    chk("a13_le_b", leb, 32'h0);
    chk("a13_err_b", errb, 1'b1);
    chk("a13_err_a", erra, 1'b0);
    v0 = 0;
    cycle();
    chk("a13_err_b_off", errb, 1'b0);

    // Reset mid-operation
    v0 = 1; a0 = 4'd7; d0 = 32'hCAFEF00D;
    cycle();
    chk("mid_le_n1", lea, 32'h0080);
    v0 = 0; reset = 1;
    cycle();
    chk("mid_le_n2", lea, 32'h0);
    chk("mid_d_n2", da, 32'h0);
    reset = 0;
    v0 = 1; v1 = 1; a0 = 4'd1; a1 = 4'd2;
    cycle();
    chk("mid_ptr", lga, 1'b0);
    v0 = 0; v1 = 0;
    cycle();

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      if (last_g == 0 && $urandom_range(1, 0) == 0) v0 = 0;
      else if (last_g == 0) begin a0 = 4'($urandom); d0 = $urandom; end
      if (last_g == 1 && $urandom_range(1, 0) == 0) v1 = 0;
      else if (last_g == 1) begin a1 = 4'($urandom); d1 = $urandom; end
      if (!v0 && $urandom_range(1, 0) == 0) begin v0 = 1; a0 = 4'($urandom); d0 = $urandom; end
      if (!v1 && $urandom_range(1, 0) == 0) begin v1 = 1; a1 = 4'($urandom); d1 = $urandom; end
      hold  = ($urandom_range(4, 0) == 0);
      reset = ($urandom_range(99, 0) == 0);
      cycle();
    end
    hold = 0; reset = 0;

    // Saturation
    do_reset();
    v0 = 1; v1 = 1; a0 = 4'd9; a1 = 4'd10;
    for (int n = 0; n < 65537; n++) begin
      d0 = n; d1 = ~n;
      cycle();
    end
    chk("sat_cnt_a", cnta, 32'hFFFF);
    chk("sat_cnt_b", cntb, 32'hFFFF);
    v0 = 0; v1 = 0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
